// File: rtl/irq_pkg.sv
// Shared types and widths for the interrupt arbiter slice.
package irq_pkg;

    localparam int LINE_W = 8;
    localparam int CPU_W  = 8;

    typedef enum logic {
        IDLE,
        OFFER
    } arb_state_t;

endpackage

// File: rtl/irq_prio_select.sv
// Combinational winner search: highest priority among eligible lines, ties go to
// the first eligible line found scanning upward (wrapping) from rr_ptr + 1.
module irq_prio_select
    import irq_pkg::*;
#(
    parameter int IRQ_PIN_COUNT = 16,
    parameter int PRIO_WIDTH    = 4
) (
    input  logic [IRQ_PIN_COUNT-1:0]            eligible,
    input  logic [IRQ_PIN_COUNT*PRIO_WIDTH-1:0] prio,
    input  logic [LINE_W-1:0]                   rr_ptr,
    output logic [LINE_W-1:0]                   winner,
    output logic                                found
);

    always_comb begin
        int                    idx;
        logic [PRIO_WIDTH-1:0] best;
        idx    = 0;
        best   = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < IRQ_PIN_COUNT; k++) begin
            // rr_ptr is always a valid line, so one wrap subtraction suffices
            idx = int'(rr_ptr) + 1 + k;
            if (idx >= IRQ_PIN_COUNT) idx -= IRQ_PIN_COUNT;
            if (eligible[idx] && (!found || prio[idx*PRIO_WIDTH +: PRIO_WIDTH] > best)) begin
                found  = 1'b1;
                best   = prio[idx*PRIO_WIDTH +: PRIO_WIDTH];
                winner = LINE_W'(idx);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-triggered interrupt arbiter with one outstanding valid/ready offer and EOI tracking.
// Define IRQ_ARB_RR_EN for round-robin tie-breaking among equal top priorities.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int IRQ_PIN_COUNT = 16,
    parameter int PRIO_WIDTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [IRQ_PIN_COUNT-1:0]            irq_in,
    input  logic [IRQ_PIN_COUNT-1:0]            irq_mask,
    input  logic [IRQ_PIN_COUNT*PRIO_WIDTH-1:0] irq_prio,
    input  logic [IRQ_PIN_COUNT*CPU_W-1:0]      irq_dest,
    output logic                                req_valid,
    output logic [LINE_W-1:0]                   req_line,
    output logic [CPU_W-1:0]                    req_cpu,
    input  logic                                req_ready,
    input  logic                                eoi,
    input  logic [LINE_W-1:0]                   eoi_line,
    output logic [IRQ_PIN_COUNT-1:0]            in_service
);

    arb_state_t                 state;
    logic [IRQ_PIN_COUNT-1:0]   irq_prev;
    logic [IRQ_PIN_COUNT-1:0]   pending;
    logic [IRQ_PIN_COUNT-1:0]   rise;
    logic [IRQ_PIN_COUNT-1:0]   eligible;
    logic [IRQ_PIN_COUNT-1:0]   hs_vec;
    logic [IRQ_PIN_COUNT-1:0]   eoi_vec;
    logic [LINE_W-1:0]          winner;
    logic [LINE_W-1:0]          rr_ptr;
    logic [CPU_W-1:0]           dest_sel;
    logic                       found;
    logic                       handshake;

    assign rise      = irq_in & ~irq_prev;
    assign eligible  = pending & ~irq_mask & ~in_service;
    assign handshake = (state == OFFER) && req_ready;

`ifdef IRQ_ARB_RR_EN
    logic [LINE_W-1:0] last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= '0;
        end else if (handshake) begin
            last_grant <= req_line;
        end
    end

    assign rr_ptr = last_grant;
`else
    // Starting after the top line makes the scan begin at line 0: fixed lowest-index tie-break
    assign rr_ptr = LINE_W'(IRQ_PIN_COUNT - 1);
`endif

    irq_prio_select #(
        .IRQ_PIN_COUNT (IRQ_PIN_COUNT),
        .PRIO_WIDTH    (PRIO_WIDTH)
    ) u_prio_select (
        .eligible (eligible),
        .prio     (irq_prio),
        .rr_ptr   (rr_ptr),
        .winner   (winner),
        .found    (found)
    );

    // Out-of-range eoi_line never matches a line, so it drops out naturally
    always_comb begin
        hs_vec   = '0;
        eoi_vec  = '0;
        dest_sel = '0;
        for (int i = 0; i < IRQ_PIN_COUNT; i++) begin
            hs_vec[i]  = handshake && (req_line == LINE_W'(i));
            eoi_vec[i] = eoi && (eoi_line == LINE_W'(i));
            if (winner == LINE_W'(i)) dest_sel = irq_dest[i*CPU_W +: CPU_W];
        end
    end

    // New edges beat handshake clears; handshake sets beat EOI clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_valid  <= 1'b0;
            req_line   <= '0;
            req_cpu    <= '0;
            irq_prev   <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            irq_prev   <= irq_in;
            pending    <= (pending & ~hs_vec) | rise;
            in_service <= (in_service & ~eoi_vec) | hs_vec;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= OFFER;
                        req_valid <= 1'b1;
                        req_line  <= winner;
                        req_cpu   <= dest_sel;
                    end
                end
                OFFER: begin
                    if (req_ready) begin
                        state     <= IDLE;
                        req_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: expected offers are queued as edges are driven.
module tb_irq_arbiter;

    localparam int N  = 16;
    localparam int PW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    irq_in;
    logic [N-1:0]    irq_mask;
    logic [N*PW-1:0] irq_prio;
    logic [N*8-1:0]  irq_dest;
    logic            req_valid;
    logic [7:0]      req_line;
    logic [7:0]      req_cpu;
    logic            req_ready;
    logic            eoi;
    logic [7:0]      eoi_line;
    logic [N-1:0]    in_service;

    typedef struct packed {
        logic [7:0] line;
        logic [7:0] cpu;
    } offer_t;

    offer_t sb_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     exp_seq[3];

    irq_arbiter #(
        .IRQ_PIN_COUNT (N),
        .PRIO_WIDTH    (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .irq_prio   (irq_prio),
        .irq_dest   (irq_dest),
        .req_valid  (req_valid),
        .req_line   (req_line),
        .req_cpu    (req_cpu),
        .req_ready  (req_ready),
        .eoi        (eoi),
        .eoi_line   (eoi_line),
        .in_service (in_service)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_dest(input int line);
        return (line == 3) ? 8'h02 : 8'(8'h10 + line);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int line, input logic [PW-1:0] p);
        irq_prio[line*PW +: PW] = p;
    endtask

    task automatic push_exp(input int line);
        offer_t o;
        o.line = 8'(line);
        o.cpu  = exp_dest(line);
        sb_q.push_back(o);
    endtask

    task automatic expect_offer(input int max_cyc);
        offer_t o;
        int     n;
        n = 0;
        while (!req_valid && n < max_cyc) begin
            tick();
            n++;
        end
        check("offer_seen", req_valid, 1);
        check("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            o = sb_q.pop_front();
            check("req_line", req_line, o.line);
            check("req_cpu", req_cpu, o.cpu);
        end
    endtask

    task automatic handshake();
        logic [7:0] l;
        l = req_line;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("valid_drop", req_valid, 0);
        check("in_service_set", in_service[l[3:0]], 1);
    endtask

    task automatic do_eoi(input int line);
        eoi      = 1'b1;
        eoi_line = 8'(line);
        tick();
        eoi      = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        irq_in    = '0;
        irq_mask  = '0;
        req_ready = 1'b0;
        eoi       = 1'b0;
        eoi_line  = '0;
        for (int i = 0; i < N; i++) begin
            set_prio(i, 4'd1);
            irq_dest[i*8 +: 8] = exp_dest(i);
        end
        tick();
        tick();
        check("rst_valid", req_valid, 0);
        check("rst_line", req_line, 0);
        check("rst_cpu", req_cpu, 0);
        check("rst_in_service", in_service, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single edge on line 3: exact two-cycle latency
        irq_in[3] = 1'b1;
        push_exp(3);
        tick();
        check("lat_t1", req_valid, 0);
        tick();
        check("lat_t2", req_valid, 1);
        expect_offer(0);
        handshake();
        do_eoi(3);
        check("eoi3_clear", in_service[3], 0);
        irq_in[3] = 1'b0;
        tick();

        // Priority: line 9 (prio 7) before line 1 (prio 2)
        set_prio(1, 4'd2);
        set_prio(9, 4'd7);
        irq_in[1] = 1'b1;
        irq_in[9] = 1'b1;
        push_exp(9);
        push_exp(1);
        expect_offer(4);
        handshake();
        expect_offer(4);
        handshake();
        do_eoi(9);
        do_eoi(1);
        check("prio_in_service_clear", in_service, 0);
        irq_in[1] = 1'b0;
        irq_in[9] = 1'b0;
        set_prio(1, 4'd1);
        set_prio(9, 4'd1);
        tick();

        // Masked line stays pending until unmasked
        irq_mask[5] = 1'b1;
        irq_in[5]   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("masked_idle", req_valid, 0);
        end
        irq_mask[5] = 1'b0;
        push_exp(5);
        expect_offer(3);
        handshake();
        do_eoi(5);
        irq_in[5] = 1'b0;
        tick();

        // Offer holds while ready is low and prio/dest/mask churn
        set_prio(7, 4'd3);
        irq_in[7] = 1'b1;
        push_exp(7);
        expect_offer(4);
        set_prio(8, 4'd15);
        irq_in[8] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_prio(7, 4'($urandom));
            irq_dest[7*8 +: 8] = 8'($urandom);
            irq_mask[7] = 1'($urandom);
            tick();
            check("hold_valid", req_valid, 1);
            check("hold_line", req_line, 7);
            check("hold_cpu", req_cpu, exp_dest(7));
        end
        irq_dest[7*8 +: 8] = exp_dest(7);
        irq_mask[7] = 1'b0;
        set_prio(7, 4'd1);
        handshake();
        push_exp(8);
        expect_offer(4);
        handshake();
        do_eoi(7);
        do_eoi(8);
        irq_in[7] = 1'b0;
        irq_in[8] = 1'b0;
        set_prio(8, 4'd1);
        tick();

        // In-service line is not re-offered until EOI; out-of-range EOI ignored
        irq_in[4] = 1'b1;
        push_exp(4);
        expect_offer(4);
        handshake();
        irq_in[4] = 1'b0;
        tick();
        irq_in[4] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("in_service_blocks", req_valid, 0);
        end
        do_eoi(200);
        check("eoi_oob_ignored", in_service[4], 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("eoi_oob_no_offer", req_valid, 0);
        end
        push_exp(4);
        do_eoi(4);
        expect_offer(4);
        handshake();
        do_eoi(4);
        irq_in[4] = 1'b0;
        tick();
        check("line4_done", in_service, 0);

        // Edge and EOI coinciding with the handshake on line 10
        irq_in[10] = 1'b1;
        push_exp(10);
        expect_offer(4);
        irq_in[10] = 1'b0;
        tick();
        irq_in[10] = 1'b1;
        req_ready  = 1'b1;
        eoi        = 1'b1;
        eoi_line   = 8'd10;
        tick();
        req_ready  = 1'b0;
        eoi        = 1'b0;
        check("coinc_valid_drop", req_valid, 0);
        check("coinc_in_service", in_service[10], 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("coinc_no_offer", req_valid, 0);
        end
        push_exp(10);
        do_eoi(10);
        expect_offer(4);
        handshake();
        check("coinc_in_service_vec", in_service, 16'h0400);

        // Reset during an offer; line held high across release re-triggers
        irq_in[10] = 1'b0;
        irq_in[11] = 1'b1;
        for (int i = 0; i < 4 && !req_valid; i++) tick();
        check("pre_reset_valid", req_valid, 1);
        check("pre_reset_line", req_line, 11);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", req_valid, 0);
        check("async_rst_in_service", in_service, 0);
        check("async_rst_line", req_line, 0);
        tick();
        rst_n = 1'b1;
        push_exp(11);
        expect_offer(4);
        handshake();
        do_eoi(11);
        irq_in[11] = 1'b0;
        tick();

        // Equal-priority tie between lines 2 and 6, both kept pending each round
`ifdef IRQ_ARB_RR_EN
        exp_seq = '{2, 6, 2};
`else
        exp_seq = '{2, 2, 2};
`endif
        set_prio(2, 4'd5);
        set_prio(6, 4'd5);
        irq_in[2] = 1'b1;
        irq_in[6] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push_exp(exp_seq[r]);
            expect_offer(4);
            irq_mask = '1;
            handshake();
            do_eoi(exp_seq[r]);
            irq_in[exp_seq[r]] = 1'b0;
            tick();
            irq_in[exp_seq[r]] = 1'b1;
            tick();
            irq_mask = '0;
        end

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter IRQ_PIN_COUNT, default 16, number of interrupt lines (2..64).
REQ-002 SHALL have parameter PRIO_WIDTH, default 4, per-line priority width; larger value is higher priority.
REQ-003 SHALL have port clk  input  1  single 50 MHz clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port irq_in  input  IRQ_PIN_COUNT  raw level interrupt lines.
REQ-006 SHALL have port irq_mask  input  IRQ_PIN_COUNT  1 = line excluded from arbitration.
REQ-007 SHALL have port irq_prio  input  IRQ_PIN_COUNT*PRIO_WIDTH  packed priorities, line i at [i*PRIO_WIDTH +: PRIO_WIDTH].
REQ-008 SHALL have port irq_dest  input  IRQ_PIN_COUNT*8  packed target processor id, line i at [i*8 +: 8].
REQ-009 SHALL have port req_valid  output  1  an interrupt is offered to the processor side.
REQ-010 SHALL have port req_line  output  8  offered line number.
REQ-011 SHALL have port req_cpu  output  8  offered target processor id.
REQ-012 SHALL have port req_ready  input  1  processor acknowledge; handshake when req_valid && req_ready.
REQ-013 SHALL have port eoi  input  1  end-of-interrupt strobe, one cycle.
REQ-014 SHALL have port eoi_line  input  8  line completed by eoi.
REQ-015 SHALL have port in_service  output  IRQ_PIN_COUNT  lines acknowledged but not yet EOI'd.

Function
REQ-016 SHALL register irq_in into irq_prev each cycle; rising edge = irq_in[i] && !irq_prev[i].
REQ-017 SHALL set pending[i] on the clock edge sampling a rising edge on line i, regardless of mask.
REQ-018 SHALL compute eligible = pending & ~irq_mask & ~in_service.
REQ-019 SHALL use FSM states IDLE, OFFER; IDLE -> OFFER when eligible != 0, latching winner line, priority and irq_dest into req_line/req_cpu.
REQ-020 SHALL select winner as highest irq_prio among eligible lines; ties resolve to lowest line index.
REQ-021 SHALL hold req_valid=1 and req_line/req_cpu stable in OFFER until handshake, independent of mask/prio/dest changes.
REQ-022 SHALL on handshake clear pending[req_line], set in_service[req_line], return to IDLE; req_valid=0 the following cycle.
REQ-023 SHALL give latency: rising edge sampled at cycle t -> pending at t+1 -> req_valid at t+2 when otherwise idle.
REQ-024 SHALL, if a new rising edge on req_line coincides with handshake, leave pending[req_line]=1 (set wins over clear).
REQ-025 SHALL on eoi clear in_service[eoi_line]; eoi_line >= IRQ_PIN_COUNT or not in service is ignored.
REQ-026 SHALL, when eoi and handshake target the same line in one cycle, leave in_service set (handshake wins).
REQ-027 SHALL never offer a line already in service; only one offer outstanding at a time.
REQ-028 SHALL keep req_valid=0 when only masked lines are pending; pending bits persist until unmasked and served.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force state IDLE, pending=0, in_service=0, irq_prev=0, req_valid=0, req_line=0, req_cpu=0.
REQ-030 SHALL on reset during OFFER drop req_valid immediately, losing the offered interrupt.
REQ-031 SHALL treat a line held high across reset release as a rising edge on the first clocked cycle.

Configuration
REQ-032 SHALL support macro IRQ_ARB_RR_EN: defined -> ties among equal highest priority resolve round-robin, starting search after the last granted line (pointer reset 0, updated on handshake); undefined -> fixed lowest-index tie-break, no pointer register.

Structure
REQ-033 SHALL place FSM state enum, line-number width (8) and processor-id width (8) in shared package irq_pkg.
REQ-034 SHALL implement winner selection in sub-module irq_prio_select (combinational, eligible/prio/rr-pointer in, winner index + found out).

Verification
REQ-035 SHALL cover: edge on line 3, dest[3]=8'h02, req_ready=1 -> req_valid at t+2, req_line=3, req_cpu=2, in_service[3]=1 next cycle.
REQ-036 SHALL cover: simultaneous edges lines 1 (prio 2) and 9 (prio 7) -> line 9 offered first; line 1 offered after handshake.
REQ-037 SHALL cover: edge on line 5 with irq_mask[5]=1 -> no req_valid; clear mask -> req_line=5 two cycles later.
REQ-038 SHALL cover: req_ready=0 for 10 cycles while prio changes -> req_line/req_cpu unchanged until handshake.
REQ-039 SHALL cover: line 4 in service, new edge on 4 -> no offer until eoi with eoi_line=4, then offered; eoi_line=200 ignored.
REQ-040 SHALL cover: rst_n asserted mid-OFFER -> req_valid=0, in_service=0 same cycle; with IRQ_ARB_RR_EN, equal-prio lines 2,6 repeatedly edged -> grants alternate 2,6,2.
